// File: rtl/systolic_pe_if.sv
// ----------------------------------------------------------------------------
// systolic_pe_if
//   Operand/result bundle for one systolic-array processing element.
//
//   The slave modport is the PE's view. It receives operands from above and
//   from the left, and it drives the forwarded operands and the partial sum.
//   The master modport is the view of the neighbour or controller that feeds
//   the PE and observes its outputs.
//
//   Signals
//     top_in      DATA_WIDTH    operand from PE above (or array top edge)
//     left_in     DATA_WIDTH    operand from PE to the left (or array left edge)
//     right_out   DATA_WIDTH    registered copy of left_in, to PE on the right
//     bottom_out  DATA_WIDTH    registered copy of top_in, to PE below
//     result      2*DATA_WIDTH  accumulator value (registered)
// ----------------------------------------------------------------------------
interface systolic_pe_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0]   top_in;
    logic [DATA_WIDTH-1:0]   left_in;
    logic [DATA_WIDTH-1:0]   right_out;
    logic [DATA_WIDTH-1:0]   bottom_out;
    logic [2*DATA_WIDTH-1:0] result;

    modport slave (
        input  top_in,
        input  left_in,
        output right_out,
        output bottom_out,
        output result
    );

    modport master (
        output top_in,
        output left_in,
        input  right_out,
        input  bottom_out,
        input  result
    );
endinterface : systolic_pe_if

// File: rtl/systolic_pe.sv
// ----------------------------------------------------------------------------
// systolic_pe
//   Output-stationary multiply-accumulate PE for the 4x4 systolic array.
//   On every non-reset rising edge, the PE performs three updates:
//     - It adds top_in*left_in (unsigned, full width) into the accumulator.
//     - It forwards left_in to right_out.
//     - It forwards top_in to bottom_out.
//   All outputs come straight from registers, so there is no combinational
//   path from any input to any output.
//
//   Ports
//     clk   in  single clock; all state updates on the rising edge
//     rst   in  synchronous, active-high; clears all three registers and
//               takes priority over accumulation
//     bus   systolic_pe_if.slave  (top_in, left_in -> right_out,
//                                  bottom_out, result)
//
//   Build option
//     PE_SATURATE_EN  When undefined (the default), the accumulator wraps
//                     modulo 2^(2*DATA_WIDTH). When defined, it clamps to
//                     all-ones on carry-out and holds there until rst.
//                     The port list is the same in both builds.
// ----------------------------------------------------------------------------
module systolic_pe #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    systolic_pe_if.slave        bus
);
    localparam int ACC_WIDTH = 2 * DATA_WIDTH;

    logic [DATA_WIDTH-1:0] r_right;
    logic [DATA_WIDTH-1:0] r_bottom;
    logic [ACC_WIDTH-1:0]  r_acc;

    logic [ACC_WIDTH-1:0]  w_product;
    logic [ACC_WIDTH:0]    w_sum;

    // Zero-extend both operands before multiplying so the product keeps its
    // full 2*DATA_WIDTH width. The sum carries one extra bit to expose the
    // carry-out.
    assign w_product = {{DATA_WIDTH{1'b0}}, bus.top_in} * {{DATA_WIDTH{1'b0}}, bus.left_in};
    assign w_sum     = {1'b0, r_acc} + {1'b0, w_product};

    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the values from before the edge. Neighbouring PEs therefore see
    // a clean one-cycle skew.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_right  <= '0;
            r_bottom <= '0;
            r_acc    <= '0;
        end else begin
            r_right  <= bus.left_in;
            r_bottom <= bus.top_in;
`ifdef PE_SATURATE_EN
            // Once the accumulator clamps, any non-zero product carries out
            // again. The accumulator therefore stays all-ones until rst.
            if (w_sum[ACC_WIDTH]) begin
                r_acc <= '1;
            end else begin
                r_acc <= w_sum[ACC_WIDTH-1:0];
            end
`else
            r_acc    <= w_sum[ACC_WIDTH-1:0];
`endif
        end
    end

    assign bus.right_out  = r_right;
    assign bus.bottom_out = r_bottom;
    assign bus.result     = r_acc;

endmodule : systolic_pe

// File: tb/tb_systolic_pe.sv
// ----------------------------------------------------------------------------
// tb_systolic_pe
//   Self-checking bench for systolic_pe (DATA_WIDTH = 8).
//
//   The reference model tracks the expected result, right_out and bottom_out
//   with plain integer arithmetic. Wrap-around is a modulo, and saturation is
//   a clamp to 65535 when PE_SATURATE_EN is defined.
//
//   Inputs change 1 ns after each rising edge, and outputs are sampled at that
//   same point, well clear of the active edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_systolic_pe;
    localparam int DW      = 8;
    localparam int ACC_MOD = 1 << (2 * DW);

    logic clk = 1'b0;
    logic rst = 1'b0;

    systolic_pe_if #(.DATA_WIDTH(DW)) bus ();

    systolic_pe #(.DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int unsigned exp_acc    = 0;
    int unsigned exp_right  = 0;
    int unsigned exp_bottom = 0;

    // Drive one edge's worth of stimulus, then advance the model by the same edge.
    task automatic apply(input logic r, input int unsigned t, input int unsigned l);
        int unsigned sum;
        rst        = r;
        bus.top_in  = DW'(t);
        bus.left_in = DW'(l);
        @(posedge clk);
        #1;
        if (r) begin
            exp_acc    = 0;
            exp_right  = 0;
            exp_bottom = 0;
        end else begin
            sum = exp_acc + t * l;
`ifdef PE_SATURATE_EN
            exp_acc = (sum >= ACC_MOD) ? ACC_MOD - 1 : sum;
`else
            exp_acc = sum % ACC_MOD;
`endif
            exp_right  = l;
            exp_bottom = t;
        end
    endtask

    task automatic test_reset();
        apply(1'b1, 9, 9);
        apply(1'b1, 9, 9);
        checks++;
        if (bus.result !== 16'd0) begin
            errors++;
            $display("FAIL reset_result: got %0d expected 0", bus.result);
        end
        checks++;
        if (bus.right_out !== 8'd0) begin
            errors++;
            $display("FAIL reset_right: got %0d expected 0", bus.right_out);
        end
        checks++;
        if (bus.bottom_out !== 8'd0) begin
            errors++;
            $display("FAIL reset_bottom: got %0d expected 0", bus.bottom_out);
        end
    endtask

    task automatic test_accumulate();
        int unsigned tv [4] = '{2, 4, 1, 7};
        int unsigned lv [4] = '{3, 5, 10, 2};
        int unsigned want [4] = '{6, 26, 36, 50};
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, tv[i], lv[i]);
            checks++;
            if (bus.result !== 16'(want[i])) begin
                errors++;
                $display("FAIL accumulate_%0d: got %0d expected %0d", i, bus.result, want[i]);
            end
        end
    endtask

    task automatic test_mid_run_reset();
        // The accumulator holds 50 when this task runs, following test_accumulate.
        apply(1'b1, 7, 2);
        checks++;
        if (bus.result !== 16'd0) begin
            errors++;
            $display("FAIL midrun_reset: got %0d expected 0", bus.result);
        end
        apply(1'b0, 3, 3);
        checks++;
        if (bus.result !== 16'd9) begin
            errors++;
            $display("FAIL midrun_restart: got %0d expected 9", bus.result);
        end
    endtask

    task automatic test_forwarding();
        apply(1'b0, 8'hA5, 8'h3C);
        checks++;
        if (bus.bottom_out !== 8'hA5 || bus.right_out !== 8'h3C) begin
            errors++;
            $display("FAIL forward_1: got bottom=%h right=%h expected bottom=a5 right=3c",
                     bus.bottom_out, bus.right_out);
        end
        apply(1'b0, 8'h5A, 8'hC3);
        checks++;
        if (bus.bottom_out !== 8'h5A || bus.right_out !== 8'hC3) begin
            errors++;
            $display("FAIL forward_2: got bottom=%h right=%h expected bottom=5a right=c3",
                     bus.bottom_out, bus.right_out);
        end
        // A zero product leaves the sum unchanged, but the operands still move on.
        apply(1'b0, 0, 8'h77);
        checks++;
        if (bus.result !== 16'(exp_acc) || bus.right_out !== 8'h77 || bus.bottom_out !== 8'h00) begin
            errors++;
            $display("FAIL forward_zero: got result=%0d right=%h bottom=%h expected result=%0d right=77 bottom=00",
                     bus.result, bus.right_out, bus.bottom_out, exp_acc);
        end
    endtask

    task automatic test_overflow();
        apply(1'b1, 0, 0);
        apply(1'b0, 255, 255);
        checks++;
        if (bus.result !== 16'd65025) begin
            errors++;
            $display("FAIL overflow_first: got %0d expected 65025", bus.result);
        end
        apply(1'b0, 255, 255);
`ifdef PE_SATURATE_EN
        checks++;
        if (bus.result !== 16'd65535) begin
            errors++;
            $display("FAIL overflow_saturate: got %0d expected 65535", bus.result);
        end
        apply(1'b0, 1, 1);
        checks++;
        if (bus.result !== 16'd65535) begin
            errors++;
            $display("FAIL overflow_hold: got %0d expected 65535", bus.result);
        end
`else
        checks++;
        if (bus.result !== 16'd64514) begin
            errors++;
            $display("FAIL overflow_wrap: got %0d expected 64514", bus.result);
        end
        apply(1'b0, 1, 1);
        checks++;
        if (bus.result !== 16'd64515) begin
            errors++;
            $display("FAIL overflow_after_wrap: got %0d expected 64515", bus.result);
        end
`endif
    endtask

    task automatic test_random();
        logic        r;
        int unsigned t;
        int unsigned l;
        apply(1'b1, 0, 0);
        for (int i = 0; i < 300; i++) begin
            r = ($urandom_range(0, 31) == 0);
            // Bias some cycles toward large operands so the sum wraps or clamps.
            if ($urandom_range(0, 3) == 0) begin
                t = $urandom_range(200, 255);
                l = $urandom_range(200, 255);
            end else begin
                t = $urandom_range(0, 255);
                l = $urandom_range(0, 255);
            end
            apply(r, t, l);
            checks++;
            if (bus.result !== 16'(exp_acc) || bus.right_out !== 8'(exp_right)
                || bus.bottom_out !== 8'(exp_bottom)) begin
                errors++;
                $display("FAIL random_%0d: got result=%0d right=%0d bottom=%0d expected result=%0d right=%0d bottom=%0d",
                         i, bus.result, bus.right_out, bus.bottom_out, exp_acc, exp_right, exp_bottom);
            end
        end
    endtask

    initial begin
        bus.top_in  = '0;
        bus.left_in = '0;
        rst         = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_accumulate();
        test_mid_run_reset();
        test_forwarding();
        test_overflow();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule : tb_systolic_pe
